mem_arbiter: RTL and testbench

- Shares the single-port byte-lane RAM (`mem`) between two requesters: instruction fetch (IF) and load/store data (D).
- Sequences each RAM access as address issue, RAM read latency, response capture, with a req/ack handshake per requester.
- Fair round-robin on conflict; sits between the processor control FSM and the `mem` instance.

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (IF, D), the arbiter and the byte-lane RAM.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH_BYTES = 4
);
    localparam int DW = 8 * DATA_WIDTH_BYTES;

    logic                                  if_req;
    logic [ADDR_WIDTH-1:0]                 if_addr;
    logic                                  if_ack;
    logic [DW-1:0]                         if_rdata;

    logic                                  d_req;
    logic [ADDR_WIDTH-1:0]                 d_addr;
    logic [DATA_WIDTH_BYTES-1:0]           d_wenableL;
    logic [DW-1:0]                         d_wdata;
    logic                                  d_ack;
    logic [DW-1:0]                         d_rdata;

    logic [ADDR_WIDTH-1:0]                 ram_addr;
    logic [DATA_WIDTH_BYTES-1:0]           ram_wenableL;
    logic [DATA_WIDTH_BYTES-1:0][7:0]      ram_w;
    logic [DATA_WIDTH_BYTES-1:0][7:0]      ram_r;
    logic                                  ram_rstL;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_wenableL, d_wdata, ram_r,
        output if_ack, if_rdata, d_ack, d_rdata, ram_addr, ram_wenableL, ram_w, ram_rstL
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_wenableL, d_wdata, ram_r,
        input  if_ack, if_rdata, d_ack, d_rdata, ram_addr, ram_wenableL, ram_w, ram_rstL
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port byte-lane RAM between IF and D requesters.
// Defining MEM_ARB_STATS_EN adds saturating grant/conflict counters.
module mem_arbiter #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH_BYTES = 4
) (
    input  logic          clk,
    input  logic          rstL,
    mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_if_grants,
    output logic [15:0]   stat_d_grants,
    output logic [15:0]   stat_conflicts
`endif
);
    localparam int DW = 8 * DATA_WIDTH_BYTES;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic {GRANT_IF, GRANT_D} grant_t;

    state_t                           state, state_n;
    grant_t                           grant, grant_n;
    grant_t                           last_grant, last_grant_n;
    logic [ADDR_WIDTH-1:0]            addr_q, addr_n;
    logic [DATA_WIDTH_BYTES-1:0]      wen_q, wen_n;
    logic [DATA_WIDTH_BYTES-1:0][7:0] w_q, w_n;
    logic                             if_ack_q, if_ack_n;
    logic                             d_ack_q, d_ack_n;
    logic [DW-1:0]                    if_rdata_q, if_rdata_n;
    logic [DW-1:0]                    d_rdata_q, d_rdata_n;
    logic                             ram_rst_q;

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            state      <= S_IDLE;
            grant      <= GRANT_IF;
            last_grant <= GRANT_IF;
            addr_q     <= '0;
            wen_q      <= '1;
            w_q        <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            addr_q     <= addr_n;
            wen_q      <= wen_n;
            w_q        <= w_n;
            if_ack_q   <= if_ack_n;
            d_ack_q    <= d_ack_n;
            if_rdata_q <= if_rdata_n;
            d_rdata_q  <= d_rdata_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        addr_n       = addr_q;
        wen_n        = wen_q;
        w_n          = w_q;
        if_ack_n     = 1'b0;
        d_ack_n      = 1'b0;
        if_rdata_n   = if_rdata_q;
        d_rdata_n    = d_rdata_q;
        case (state)
            S_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    // On a tie the requester not served last wins.
                    if (bus.if_req && bus.d_req)
                        grant_n = (last_grant == GRANT_IF) ? GRANT_D : GRANT_IF;
                    else
                        grant_n = bus.d_req ? GRANT_D : GRANT_IF;
                    if (grant_n == GRANT_D) begin
                        addr_n = bus.d_addr;
                        wen_n  = bus.d_wenableL;
                        w_n    = bus.d_wdata;
                    end else begin
                        addr_n = bus.if_addr;
                        wen_n  = '1;
                    end
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wen_n   = '1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (grant == GRANT_D) begin
                    d_ack_n   = 1'b1;
                    d_rdata_n = bus.ram_r;
                end else begin
                    if_ack_n   = 1'b1;
                    if_rdata_n = bus.ram_r;
                end
                last_grant_n = grant;
                state_n      = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // RAM reset follows rstL low immediately but releases on the next clock edge.
    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) ram_rst_q <= 1'b0;
        else       ram_rst_q <= 1'b1;
    end

    assign bus.if_ack       = if_ack_q;
    assign bus.d_ack        = d_ack_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_wenableL = wen_q;
    assign bus.ram_w        = w_q;
    assign bus.ram_rstL     = ram_rst_q;

`ifdef MEM_ARB_STATS_EN
    logic        conflict;
    logic [15:0] if_cnt, d_cnt, c_cnt;

    assign conflict = (state == S_IDLE) && bus.if_req && bus.d_req;

    always_ff @(posedge clk or negedge rstL) begin
        if (!rstL) begin
            if_cnt <= '0;
            d_cnt  <= '0;
            c_cnt  <= '0;
        end else begin
            if (if_ack_q && (if_cnt != '1)) if_cnt <= if_cnt + 16'd1;
            if (d_ack_q && (d_cnt != '1))   d_cnt  <= d_cnt + 16'd1;
            if (conflict && (c_cnt != '1))  c_cnt  <= c_cnt + 16'd1;
        end
    end

    assign stat_if_grants = if_cnt;
    assign stat_d_grants  = d_cnt;
    assign stat_conflicts = c_cnt;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand sequences and random traffic vs a word-level model.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int NB = 4;

    logic clk  = 1'b0;
    logic rstL = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH_BYTES(NB)) bus();

`ifdef MEM_ARB_STATS_EN
    logic [15:0] s_if, s_d, s_c;
`endif

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH_BYTES(NB)) dut (
        .clk  (clk),
        .rstL (rstL),
        .bus  (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_if_grants (s_if),
        .stat_d_grants  (s_d),
        .stat_conflicts (s_c)
`endif
    );

    // Synchronous single-port RAM: read-before-write, data valid after the address edge.
    bit [31:0] ram_mem [0:255];
    always @(posedge clk) begin
        bus.ram_r <= ram_mem[bus.ram_addr[7:0]];
        for (int i = 0; i < NB; i++)
            if (!bus.ram_wenableL[i]) ram_mem[bus.ram_addr[7:0]][8*i +: 8] <= bus.ram_w[i];
    end

    int cyc = 0;
    int wen_low = 0;
    int overlap = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.ram_wenableL != 4'hF) wen_low <= wen_low + 1;
    always @(negedge clk) if (bus.if_ack && bus.d_ack) overlap <= overlap + 1;

    int tests = 0;
    int fails = 0;
    int spurious = 0;
    int if_ack_cyc = 0;
    int d_ack_cyc = 0;

    // Reference model: expected memory contents and arbitration history.
    bit [31:0] ref_mem [0:255];
    bit        ref_last_d = 1'b0;
    logic [31:0] last_ir = '0;
    logic [31:0] last_dr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_access(input logic [15:0] a, input logic [3:0] wen,
                                               input logic [31:0] wd);
        logic [31:0] old;
        old = ref_mem[a[7:0]];
        for (int i = 0; i < NB; i++)
            if (!wen[i]) ref_mem[a[7:0]][8*i +: 8] = wd[8*i +: 8];
        return old;
    endfunction

    task automatic run_txn(input bit do_if, input bit do_d, input logic [15:0] ia,
                           input logic [15:0] da, input logic [3:0] wen, input logic [31:0] wd,
                           output logic [31:0] ir, output logic [31:0] dr,
                           output int ilat, output int dlat);
        bit pi, pd;
        int wl0;
        ir = '0; dr = '0; ilat = -1; dlat = -1;
        pi = do_if; pd = do_d; wl0 = wen_low;
        bus.if_addr = ia; bus.d_addr = da; bus.d_wenableL = wen; bus.d_wdata = wd;
        bus.if_req = do_if; bus.d_req = do_d;
        for (int e = 1; e <= 12 && (pi || pd); e++) begin
            @(posedge clk); #1;
            if (bus.if_ack) begin
                if (pi) begin ir = bus.if_rdata; ilat = e; pi = 0; bus.if_req = 1'b0; if_ack_cyc = cyc; end
                else spurious++;
            end
            if (bus.d_ack) begin
                if (pd) begin dr = bus.d_rdata; dlat = e; pd = 0; bus.d_req = 1'b0; d_ack_cyc = cyc; end
                else spurious++;
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        check("wen_low_cycles", 32'(wen_low - wl0), (do_d && wen != 4'hF) ? 32'd1 : 32'd0);
    endtask

    // Predict grant order, data and latency from the arbitration rules, then run and compare.
    task automatic txn_ref(input bit do_if, input bit do_d, input logic [15:0] ia,
                           input logic [15:0] da, input logic [3:0] wen, input logic [31:0] wd);
        logic [31:0] eir, edr, ir, dr;
        int eil, edl, il, dl;
        eir = last_ir; edr = last_dr; eil = -1; edl = -1;
        if (do_if && do_d) begin
            if (!ref_last_d) begin
                edr = ref_access(da, wen, wd); eir = ref_access(ia, 4'hF, 32'h0);
                edl = 3; eil = 7; ref_last_d = 1'b0;
            end else begin
                eir = ref_access(ia, 4'hF, 32'h0); edr = ref_access(da, wen, wd);
                eil = 3; edl = 7; ref_last_d = 1'b1;
            end
        end else if (do_if) begin
            eir = ref_access(ia, 4'hF, 32'h0); eil = 3; ref_last_d = 1'b0;
        end else if (do_d) begin
            edr = ref_access(da, wen, wd); edl = 3; ref_last_d = 1'b1;
        end
        run_txn(do_if, do_d, ia, da, wen, wd, ir, dr, il, dl);
        if (do_if) begin
            check("rand_if_rdata", ir, eir);
            check("rand_if_latency", 32'(il), 32'(eil));
        end else check("rand_if_rdata_hold", bus.if_rdata, last_ir);
        if (do_d) begin
            check("rand_d_rdata", dr, edr);
            check("rand_d_latency", 32'(dl), 32'(edl));
        end else check("rand_d_rdata_hold", bus.d_rdata, last_dr);
        last_ir = eir; last_dr = edr;
    endtask

    task automatic do_reset();
        rstL = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_wen", 32'(bus.ram_wenableL), 32'hF);
        check("rst_ram_w", bus.ram_w, 32'd0);
        check("rst_ram_rstL", 32'(bus.ram_rstL), 32'd0);
        rstL = 1'b1; #1;
        check("ram_rstL_held", 32'(bus.ram_rstL), 32'd0);
        @(posedge clk); #1;
        check("ram_rstL_release", 32'(bus.ram_rstL), 32'd1);
        ref_last_d = 1'b0; last_ir = '0; last_dr = '0;
    endtask

    typedef struct {
        bit          is_d;
        logic [15:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [9];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ir, dr, tmp;
        int il, dl, c1;
        int order [$];
        int times [$];
        bit g;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wenableL = '1; bus.d_wdata = '0;

        do_reset();

        vt[0] = '{1'b1, 16'h0010, 4'b0000, 32'h00A00093, 32'h00000000};
        vt[1] = '{1'b1, 16'h0020, 4'b0000, 32'h11223344, 32'h00000000};
        vt[2] = '{1'b0, 16'h0010, 4'b1111, 32'h00000000, 32'h00A00093};
        vt[3] = '{1'b1, 16'h0020, 4'b1110, 32'hDEADBEEF, 32'h11223344};
        vt[4] = '{1'b1, 16'h0020, 4'b1111, 32'h00000000, 32'h112233EF};
        vt[5] = '{1'b0, 16'h0020, 4'b1111, 32'h00000000, 32'h112233EF};
        vt[6] = '{1'b1, 16'h0030, 4'b0000, 32'hAABBCCDD, 32'h00000000};
        vt[7] = '{1'b1, 16'h0030, 4'b0101, 32'h11223344, 32'hAABBCCDD};
        vt[8] = '{1'b1, 16'h0030, 4'b1111, 32'h00000000, 32'h11BB33DD};

        foreach (vt[k]) begin
            run_txn(!vt[k].is_d, vt[k].is_d, vt[k].addr, vt[k].addr, vt[k].wen, vt[k].wdata,
                    ir, dr, il, dl);
            tmp = ref_access(vt[k].addr, vt[k].is_d ? vt[k].wen : 4'hF, vt[k].wdata);
            if (vt[k].is_d) begin
                check("vec_d_rdata", dr, vt[k].exp);
                check("vec_d_latency", 32'(dl), 32'd3);
                check("vec_if_hold", bus.if_rdata, last_ir);
                last_dr = vt[k].exp; ref_last_d = 1'b1;
            end else begin
                check("vec_if_rdata", ir, vt[k].exp);
                check("vec_if_latency", 32'(il), 32'd3);
                check("vec_d_hold", bus.d_rdata, last_dr);
                last_ir = vt[k].exp; ref_last_d = 1'b0;
            end
        end

        // Back-to-back IF reads, second request raised the cycle after the first ack.
        txn_ref(1'b1, 1'b0, 16'h0010, 16'h0, 4'hF, 32'h0);
        c1 = if_ack_cyc;
        txn_ref(1'b1, 1'b0, 16'h0020, 16'h0, 4'hF, 32'h0);
        check("b2b_ack_gap", 32'(if_ack_cyc - c1), 32'd4);

        for (int n = 0; n < 60; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            txn_ref(mode != 1, mode != 0, 16'({$urandom_range(0, 15), 2'b00}),
                    16'({$urandom_range(0, 15), 2'b00}), 4'($urandom_range(0, 15)), $urandom);
        end

        // Continuous contention from reset: both requests held across four accesses.
        do_reset();
        bus.if_addr = 16'h0010; bus.d_addr = 16'h0020; bus.d_wenableL = 4'hF;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        for (int e = 0; e < 40 && order.size() < 4; e++) begin
            @(posedge clk); #1;
            if (bus.if_ack) begin order.push_back(0); times.push_back(cyc); end
            if (bus.d_ack) begin order.push_back(1); times.push_back(cyc); end
            if (order.size() >= 4) begin bus.if_req = 1'b0; bus.d_req = 1'b0; end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(posedge clk); #1;
        check("cont_access_count", 32'(order.size()), 32'd4);
        if (order.size() == 4) begin
            g = ref_last_d;
            for (int i = 0; i < 4; i++) begin
                g = !g;
                check("cont_grant_order", 32'(order[i]), 32'(g));
                if (i > 0) check("cont_ack_gap", 32'(times[i] - times[i-1]), 32'd4);
            end
            ref_last_d = g;
        end
        check("cont_if_rdata", bus.if_rdata, ref_mem[8'h10]);
        check("cont_d_rdata", bus.d_rdata, ref_mem[8'h20]);
        last_ir = ref_mem[8'h10]; last_dr = ref_mem[8'h20];
`ifdef MEM_ARB_STATS_EN
        check("stat_if_grants", 32'(s_if), 32'd2);
        check("stat_d_grants", 32'(s_d), 32'd2);
        check("stat_conflicts_3or4", 32'(s_c == 16'd3 || s_c == 16'd4), 32'd1);
`endif

        // Reset asserted while a D read sits in WAIT: the access is dropped silently.
        bus.d_addr = 16'h0020; bus.d_wenableL = 4'hF; bus.d_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstL = 1'b0; #1;
        check("midrst_d_ack", 32'(bus.d_ack), 32'd0);
        check("midrst_ram_wen", 32'(bus.ram_wenableL), 32'hF);
        check("midrst_ram_rstL", 32'(bus.ram_rstL), 32'd0);
        do_reset();
        check("midrst_no_late_ack", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        txn_ref(1'b1, 1'b0, 16'h0010, 16'h0, 4'hF, 32'h0);

        check("acks_never_coincide", 32'(overlap), 32'd0);
        check("no_spurious_acks", 32'(spurious), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
